// File: rtl/function_generator_playback_sequencer.sv
// Waveform-memory read sequencer for the function-generator output path.
// Plays [start, end) continuously or as triggered bursts of N passes.
// Configuration is staged in a shadow set and only takes effect when the
// block is not playing or at a pass boundary, so the output never glitches.
module function_generator_playback_sequencer #(
  parameter int ADDR_WIDTH  = 14,
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_DELAY  = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  start_address,
  input  logic [ADDR_WIDTH-1:0]  end_address,
  input  logic [COUNT_WIDTH-1:0] repeat_count,
  input  logic [1:0]             mode,
  input  logic                   config_load,
  input  logic                   trigger,
  input  logic                   abort,
  output logic [ADDR_WIDTH-1:0]  read_address,
  output logic                   read_enable,
  output logic                   sync_out,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] pass_count,
  output logic                   config_error
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PLAY} state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_re, r_busy, r_done, r_sync_raw;
  logic [COUNT_WIDTH-1:0] r_pc;

  // active and shadow configuration
  logic [ADDR_WIDTH-1:0]  r_act_start, r_act_end, r_sh_start, r_sh_end;
  logic [COUNT_WIDTH-1:0] r_act_rep, r_sh_rep;
  logic [1:0]             r_act_mode, r_sh_mode;
  logic                   r_pending, r_cfg_err;

  // trigger synchronizer and rising-edge detect
  logic r_trg_s1, r_trg_s2, r_trg_prev, r_trg_rise;

  logic                   w_load_ok, w_boundary, w_apply, w_more;
  logic [ADDR_WIDTH-1:0]  w_nx_start;
  logic [COUNT_WIDTH-1:0] w_nx_rep, w_pc_inc;
  logic [1:0]             w_nx_mode;
  logic [COUNT_WIDTH:0]   w_pc_plus1;

  assign w_load_ok  = config_load && (end_address > start_address);
  assign w_boundary = (r_state == S_PLAY) && (r_addr == r_act_end - ADDR_WIDTH'(1));
  // shadow is applied whenever not playing, or at a pass boundary; never on abort
  assign w_apply    = !abort && r_pending && ((r_state != S_PLAY) || w_boundary);

  // configuration that will be active after this edge
  assign w_nx_start = r_pending ? r_sh_start : r_act_start;
  assign w_nx_rep   = r_pending ? r_sh_rep   : r_act_rep;
  assign w_nx_mode  = r_pending ? r_sh_mode  : r_act_mode;

  assign w_pc_inc   = (&r_pc) ? r_pc : r_pc + COUNT_WIDTH'(1);
  assign w_pc_plus1 = {1'b0, r_pc} + (COUNT_WIDTH+1)'(1);
  // another pass follows this boundary
  assign w_more     = (w_nx_mode == 2'd1) ||
                      ((w_nx_mode == 2'd2) &&
                       ((w_nx_rep == '0) || (w_pc_plus1 < {1'b0, w_nx_rep})));

  // trigger: two-flop synchronizer followed by a registered rising-edge pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_trg_s1   <= 1'b0;
      r_trg_s2   <= 1'b0;
      r_trg_prev <= 1'b0;
      r_trg_rise <= 1'b0;
    end else begin
      r_trg_s1   <= trigger;
      r_trg_s2   <= r_trg_s1;
      r_trg_prev <= r_trg_s2;
      r_trg_rise <= r_trg_s2 && !r_trg_prev;
    end
  end

  // shadow capture, validity flag, and shadow-to-active transfer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_act_start <= '0;
      r_act_end   <= '0;
      r_act_rep   <= '0;
      r_act_mode  <= '0;
      r_sh_start  <= '0;
      r_sh_end    <= '0;
      r_sh_rep    <= '0;
      r_sh_mode   <= '0;
      r_pending   <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_start <= r_sh_start;
        r_act_end   <= r_sh_end;
        r_act_rep   <= r_sh_rep;
        r_act_mode  <= r_sh_mode;
        r_pending   <= 1'b0;
      end
      // a load in the same cycle as a transfer re-arms pending (last one wins)
      if (config_load) begin
        if (w_load_ok) begin
          r_sh_start <= start_address;
          r_sh_end   <= end_address;
          r_sh_rep   <= repeat_count;
          r_sh_mode  <= mode;
          r_pending  <= 1'b1;
          r_cfg_err  <= 1'b0;
        end else begin
          r_cfg_err  <= 1'b1;
        end
      end
    end
  end

  // playback FSM with registered address, enable, sync and status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_re       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pc       <= '0;
      r_sync_raw <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_sync_raw <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_re    <= 1'b0;
        r_busy  <= 1'b0;
        r_addr  <= r_act_start;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_addr <= r_act_start;
            // a pending set is transferred first so play starts on the new region
            if (!r_pending) begin
              if (r_act_mode == 2'd1) begin
                r_state    <= S_PLAY;
                r_re       <= 1'b1;
                r_busy     <= 1'b1;
                r_pc       <= '0;
                r_sync_raw <= 1'b1;
              end else if (r_act_mode == 2'd2) begin
                r_state <= S_ARMED;
              end
            end
          end
          S_ARMED: begin
            r_addr <= w_nx_start;
            if (w_nx_mode != 2'd2) begin
              r_state <= S_IDLE;
            end else if (r_trg_rise) begin
              r_state    <= S_PLAY;
              r_re       <= 1'b1;
              r_busy     <= 1'b1;
              r_pc       <= '0;
              r_sync_raw <= 1'b1;
            end
          end
          S_PLAY: begin
            if (w_boundary) begin
              r_pc   <= w_pc_inc;
              r_addr <= w_nx_start;
              if (w_more) begin
                r_sync_raw <= 1'b1;
              end else begin
                r_re    <= 1'b0;
                r_busy  <= 1'b0;
                if (w_nx_mode == 2'd2) begin
                  r_done  <= 1'b1;
                  r_state <= S_ARMED;
                end else begin
                  r_state <= S_IDLE;
                end
              end
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_re    <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // sync is delayed to line up with the word leaving the memory
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign sync_out = r_sync_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] r_sync_pipe;
      // shift register; not cleared by abort
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_sync_pipe <= '0;
        end else begin
          r_sync_pipe[0] <= r_sync_raw;
          for (int i = 1; i < SYNC_DELAY; i++) r_sync_pipe[i] <= r_sync_pipe[i-1];
        end
      end
      assign sync_out = r_sync_pipe[SYNC_DELAY-1];
    end
  endgenerate

  assign read_address = r_addr;
  assign read_enable  = r_re;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass_count   = r_pc;
  assign config_error = r_cfg_err;

endmodule

// File: tb/tb_function_generator_playback_sequencer.sv
// Directed bench for the playback sequencer: a cycle table for continuous
// and burst play, plus hand sequences for reload, invalid load, abort and reset.
module tb_function_generator_playback_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [13:0] start_address = '0, end_address = '0;
  logic [15:0] repeat_count = '0;
  logic [1:0]  mode = '0;
  logic        config_load = 1'b0, trigger = 1'b0, abort = 1'b0;
  logic [13:0] read_address;
  logic        read_enable, sync_out, busy, done, config_error;
  logic [15:0] pass_count;

  int nchk = 0;
  int nerr = 0;

  function_generator_playback_sequencer #(
    .ADDR_WIDTH(14), .COUNT_WIDTH(16), .SYNC_DELAY(2)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .start_address(start_address), .end_address(end_address),
    .repeat_count(repeat_count), .mode(mode),
    .config_load(config_load), .trigger(trigger), .abort(abort),
    .read_address(read_address), .read_enable(read_enable),
    .sync_out(sync_out), .busy(busy), .done(done),
    .pass_count(pass_count), .config_error(config_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          rst;
    bit          ld;
    logic [13:0] st, en;
    logic [15:0] rep;
    logic [1:0]  md;
    bit          trg;
    bit          ca;    // compare read_address
    logic [13:0] addr;
    bit          re, sy, bs, dn;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit ld, int st, int en, int rep, int md, bit trg,
                              bit ca, int addr, bit re, bit sy, bit bs, bit dn, int pc);
    vec_t v;
    v.rst = rst; v.ld = ld; v.st = 14'(st); v.en = 14'(en); v.rep = 16'(rep);
    v.md = 2'(md); v.trg = trg; v.ca = ca; v.addr = 14'(addr);
    v.re = re; v.sy = sy; v.bs = bs; v.dn = dn; v.pc = 16'(pc);
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(bit ld, int st, int en, int rep, int md, bit ab);
    config_load   = ld;
    start_address = 14'(st);
    end_address   = 14'(en);
    repeat_count  = 16'(rep);
    mode          = 2'(md);
    abort         = ab;
  endtask

  task automatic idle();
    config_load = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    trigger = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  // waits up to 'lim' cycles for read_enable=1 while pulsing the trigger
  task automatic trig_and_wait(string nm, int lim);
    bit found = 0;
    trigger = 1'b1;
    for (int i = 0; i < lim && !found; i++) begin
      tick();
      if (i == 2) trigger = 1'b0;
      if (read_enable) found = 1;
    end
    trigger = 1'b0;
    chk(nm, int'(found), 1);
  endtask

  initial begin
    bit found;

    // reset values before any clock edge
    #2 reset_n = 1'b0;
    #1;
    chk("rst_addr", read_address, 0);
    chk("rst_re",   read_enable, 0);
    chk("rst_sync", sync_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc",   pass_count, 0);
    chk("rst_err",  config_error, 0);

    // continuous play [4,8)
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,4,8,0,1,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,4,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,5,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,6,1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,7,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,4,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,5,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,6,1,1,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,7,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,4,1,0,1,0,2));
    // burst [0,3), repeat 2, trigger rising before the 4th edge
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,3,2,2,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,2,1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,2,1,1,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,1,2));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,2));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,0,0,2));

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        config_load   = tbl[i].ld;
        start_address = tbl[i].st;
        end_address   = tbl[i].en;
        repeat_count  = tbl[i].rep;
        mode          = tbl[i].md;
        trigger       = tbl[i].trg;
        abort         = 1'b0;
        tick();
        if (tbl[i].ca) chk($sformatf("tbl%0d_addr", i), read_address, tbl[i].addr);
        chk($sformatf("tbl%0d_re",   i), read_enable, tbl[i].re);
        chk($sformatf("tbl%0d_sync", i), sync_out, tbl[i].sy);
        chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bs);
        chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
        chk($sformatf("tbl%0d_pc",   i), pass_count, tbl[i].pc);
      end
    end
    trigger = 1'b0;

    // reload mid-pass: [0,16) then [32,40) loaded at address 5
    do_reset();
    drv(1, 0, 16, 0, 1, 0); tick(); idle();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (read_enable && read_address == 5) found = 1;
    end
    chk("C_reach5", int'(found), 1);
    drv(1, 32, 40, 0, 1, 0); tick(); idle();
    for (int a = 6; a <= 15; a++) begin
      chk($sformatf("C_addr%0d", a), read_address, a);
      tick();
    end
    chk("C_wrap_addr", read_address, 32);
    chk("C_wrap_pc", pass_count, 1);
    tick();
    chk("C_addr33", read_address, 33);
    chk("C_sync_early", sync_out, 0);
    tick();
    chk("C_sync32", sync_out, 1);

    // invalid load keeps the region, then a one-word region
    drv(1, 10, 10, 0, 1, 0); tick(); idle();
    chk("D_err_set", config_error, 1);
    for (int i = 0; i < 10; i++) begin
      chk("D_region", int'(read_address >= 32 && read_address < 40), 1);
      tick();
    end
    chk("D_err_sticky", config_error, 1);
    drv(1, 10, 11, 0, 1, 0); tick(); idle();
    chk("D_err_clr", config_error, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (read_address == 10) found = 1;
      else tick();
    end
    chk("D_reach10", int'(found), 1);
    for (int i = 0; i < 6; i++) begin
      chk("D_addr10", read_address, 10);
      if (i >= 2) chk("D_sync_every", sync_out, 1);
      tick();
    end

    // abort in the second pass of a burst, then restart
    do_reset();
    drv(1, 0, 10, 3, 2, 0); tick(); idle();
    repeat (3) tick();
    trig_and_wait("E_start", 12);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pass_count == 1 && read_address == 6) found = 1;
      else tick();
    end
    chk("E_reach6", int'(found), 1);
    drv(0, 0, 10, 3, 2, 1); tick(); idle();
    chk("E_abort_re", read_enable, 0);
    chk("E_abort_busy", busy, 0);
    chk("E_abort_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("E_no_done", done, 0);
      chk("E_idle_re", read_enable, 0);
    end
    trig_and_wait("E_restart", 12);
    chk("E_restart_addr", read_address, 0);
    chk("E_restart_pc", pass_count, 0);

    // asynchronous reset mid-play
    do_reset();
    drv(1, 4, 8, 0, 1, 0); tick(); idle();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (read_enable) found = 1;
    end
    repeat (2) tick();
    chk("F_playing", int'(found && busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("F_addr", read_address, 0);
    chk("F_re",   read_enable, 0);
    chk("F_busy", busy, 0);
    chk("F_pc",   pass_count, 0);
    chk("F_sync", sync_out, 0);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("F_stay_idle", int'(read_enable || busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/function_generator_playback_sequencer.md
# function_generator_playback_sequencer

Sequences the read port of the waveform memory that feeds the OSERDES function-generator output: one word address per word-clock cycle. Plays the programmed region [start, end) continuously, or as triggered bursts of N passes. New start/end/mode/count values are staged in shadow registers and take effect only at a pass boundary, so the waveform never glitches. Emits a sync pulse aligned to the first word of each pass as it leaves the memory. Sits between the SPI register file (configuration) and the dual-port waveform RAM (read port).

## Interface
- ADDR_WIDTH, 14: word-address width of the memory read port
- COUNT_WIDTH, 16: width of repeat_count and pass_count
- SYNC_DELAY, 2: read latency of the memory in cycles; sync_out is delayed by this amount
- clock  input  1  word clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start_address  input  ADDR_WIDTH  first word of the waveform
- end_address  input  ADDR_WIDTH  exclusive end; last word played is end_address-1
- repeat_count  input  COUNT_WIDTH  passes per burst; 0 = unlimited
- mode  input  2  0 = idle, 1 = continuous, 2 = triggered burst, 3 = treated as 0
- config_load  input  1  one-cycle pulse; captures start/end/repeat/mode into the shadow set
- trigger  input  1  asynchronous external trigger; rising edge is used
- abort  input  1  one-cycle pulse; stops playback immediately
- read_address  output  ADDR_WIDTH  memory read address
- read_enable  output  1  high while playing
- sync_out  output  1  one-cycle pulse marking the first word of each pass at the memory output
- busy  output  1  high in PLAYING
- done  output  1  one-cycle pulse when a burst completes
- pass_count  output  COUNT_WIDTH  completed passes in the current burst
- config_error  output  1  sticky flag: the last config_load was rejected

## Operation
- Active config registers (start, end, repeat, mode):
  - Reset value is 0/0/0/0, so the block comes out of reset in IDLE.
  - They are loaded only from the shadow set.
- config_load with end_address <= start_address:
  - The load is rejected and config_error is set.
  - The next valid load clears config_error.
- Valid config_load:
  - Marks the shadow set pending.
  - In IDLE or ARMED it is applied on the next clock.
  - In PLAYING it is applied at the next pass boundary.
  - A second load before the boundary overwrites the shadow set (last one wins).
- States:
  - IDLE: read_enable=0, read_address=active start. Goes to PLAYING if active mode=1. Goes to ARMED if active mode=2.
  - ARMED: waits for a synchronized trigger rising edge, then goes to PLAYING. If a config load changes active mode to 0, goes to IDLE.
  - PLAYING: read_enable=1. read_address increments by 1 each cycle.
- Pass boundary (the cycle in which read_address = active end-1):
  - pass_count increments, saturating at all-ones.
  - Any pending shadow set is applied.
  - Then, using the new active mode:
    - mode 1, or mode 2 with repeat=0, or mode 2 with pass_count+1 < repeat: read_address wraps to start, a sync is raised, and the block stays in PLAYING.
    - mode 2 with the burst complete: pulse done and go to ARMED.
    - mode 0: go to IDLE (no done pulse).
- Entry to PLAYING: pass_count clears to 0, read_address = active start, and a sync is raised.
- Raw sync is asserted in the same cycle as the first address of a pass. sync_out is that signal delayed SYNC_DELAY cycles. The delay pipeline is not flushed by abort.
- abort: highest priority. Next state is IDLE and read_enable drops next cycle. A pending shadow set is kept.
- A trigger edge seen in PLAYING or IDLE is ignored (no retrigger, no queuing).
- A one-word waveform (end = start+1) raises sync every cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH. Since end > start is enforced, no wrap inside a pass is possible.

## Timing
- Reset values:
  - read_address=0, read_enable=0, sync_out=0, busy=0, done=0, pass_count=0, config_error=0.
  - Trigger synchronizer and sync pipeline cleared; state=IDLE.
- Trigger path: 2-flop synchronizer plus an edge-detect flop.
  - trigger rising before edge k gives edge-detect at edge k+2.
  - PLAYING, with first address = start, begins at edge k+3.
- config_load at edge j in IDLE with mode=1: active config at j+1, PLAYING at j+2.
- At the burst end, done is high for exactly the cycle after the last word. read_enable is 0 in that same cycle.
- busy equals (state==PLAYING) and is registered.

## Test plan
- Continuous play, start=4, end=8, mode=1:
  - Required: read_address 4,5,6,7,4,5,... with no gaps.
  - Required: sync_out high SYNC_DELAY cycles after each address-4 cycle.
- Burst play, start=0, end=3, repeat=2, mode=2, trigger pulse:
  - Required: after 3-cycle sync latency, addresses 0,1,2,0,1,2.
  - Required: then done=1 for one cycle, pass_count=2, state ARMED, read_enable=0.
- Reload mid-pass, playing [0,16), config_load with [32,40) at address 5:
  - Required: addresses 5..15, then 32 with sync.
  - Required: no address from the new region before 15.
- Invalid load, start=10, end=10:
  - Required: config_error=1 and the active region is unchanged.
  - Required: a following load of [10,11) clears the error and sync asserts every cycle.
- abort at address 6 of a burst:
  - Required: read_enable=0 and busy=0 next cycle, no done pulse.
  - Required: a later trigger restarts at start with pass_count=0.
- Async reset_n asserted mid-PLAYING:
  - Required: all outputs at reset values immediately, without waiting for a clock edge.
  - Required: after release, the block stays IDLE until a new config_load.
